uart_rx_os32: RTL
=================

Name: uart_rx_os32

Overview:
- UART receiver that consumes the x32 oversample tick from the baud generator and deserializes RXD into bytes.
- Frame format: start bit, DATA_BITS data bits LSB first, optional parity bit, one stop bit.
- Presents each byte through a single-entry holding register with a valid/ack handshake and per-byte error flags.
- Sits between the pad and the UART host interface.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.

Ports:
CLK  in  1  clock.
RST  in  1  reset, asynchronous, active-low.
TICK_X32  in  1  one-cycle oversample strobe; 32 ticks = one bit period.
RXD  in  1  serial line; asynchronous; idle high.
RX_EN  in  1  receiver enable; low forces IDLE and aborts any frame in progress.
PARITY_EN  in  1  parity bit present; latched at start detection.
PARITY_ODD  in  1  1 = odd parity, 0 = even; latched at start detection.
RX_ACK  in  1  consumer accepts the held byte.
RX_DATA  out  DATA_BITS  held byte; unused MSBs are 0.
RX_VALID  out  1  held byte available.
FRAME_ERR  out  1  stop bit of the held byte sampled 0.
PARITY_ERR  out  1  parity mismatch on the held byte.
OVERRUN  out  1  sticky; a completed frame was dropped because the holding register was full.
BUSY  out  1  FSM not in IDLE.

Behaviour:
- Reset (RST low): all outputs 0; synchronizer flops 1; FSM in IDLE; counters 0. Reset mid-frame discards the partial frame.
- Synchronizer: 2-flop synchronizer on RXD; all logic uses the synced value rxs.
- Vote register: 3-bit shift register of rxs, shifted only on TICK_X32. The bit value is the majority of the 3 entries, the current tick's rxs included.
- Sample counter: 5 bits, increments on TICK_X32 only and wraps 31->0. With no ticks, the FSM and counters hold.
- IDLE:
  - A falling edge on rxs (previous 1, current 0) with RX_EN=1 moves to START.
  - On entry: counter cleared to 0; PARITY_EN and PARITY_ODD latched.
- START:
  - On the tick with counter==15 (mid-bit), read the vote.
  - Vote 1: false start; return to IDLE with no flags.
  - Vote 0: clear counter, bit index = 0, go to DATA.
- DATA:
  - On each tick with counter==31, shift the vote into the data shift register LSB-first and increment the bit index.
  - After DATA_BITS bits: go to PARITY if the latched PARITY_EN=1, else STOP.
- PARITY: on the tick with counter==31, compute expected = XOR(data) XOR latched PARITY_ODD; perr = (vote != expected). Go to STOP.
- STOP: on the tick with counter==31, ferr = (vote == 0). Perform the completion action, then go to IDLE in the same cycle, so the next start edge is detectable immediately.
- Completion action:
  - If RX_VALID=0, or RX_ACK=1 in the same cycle: load RX_DATA, FRAME_ERR=ferr, PARITY_ERR=perr (0 when parity is disabled); RX_VALID=1 next cycle.
  - Otherwise: the frame is dropped, OVERRUN is set to 1, and the held byte and its flags are unchanged.
- Handshake:
  - RX_ACK with RX_VALID=1 clears RX_VALID and OVERRUN next cycle.
  - RX_ACK with RX_VALID=0 has no effect.
  - Simultaneous ACK and completion: the new byte loads, RX_VALID stays 1, OVERRUN is cleared, not set.
  - RX_DATA and the flags hold their value after ACK until the next load.
- Line held low after a frame error (break): no new falling edge, so no new frame; the receiver stays in IDLE until rxs returns high and falls again.
- RX_EN low: FSM forced to IDLE on the next cycle and the partial frame is discarded. The holding register and OVERRUN are unaffected.
- BUSY = (state != IDLE).
- Latency: RX_VALID rises 1 cycle after the stop-bit mid-sample tick.

Test Plan:
- Byte 0xA5, 8N1. Bench uses TICK_X32 every 11 CLK and a bit period of 352 CLK. -> RX_DATA=0xA5, RX_VALID=1, FRAME_ERR=0, PARITY_ERR=0; BUSY low after the stop mid-sample.
- PARITY_EN=1, PARITY_ODD=0:
  - Send 0x03 with parity bit 0 -> PARITY_ERR=0.
  - Resend 0x03 with parity bit 1 -> PARITY_ERR=1, byte still 0x03.
- Send 0x55 with stop bit 0 -> FRAME_ERR=1, RX_DATA=0x55. Then hold the line low 2000 CLK -> no further RX_VALID.
- False start: 8-tick low glitch on RXD -> returns to IDLE, no RX_VALID. Single-tick inverted glitch at mid-bit of data bit 3 of 0x00 -> still decodes 0x00 via the majority vote.
- Overrun: send 0x11 and 0x22 without ACK -> RX_DATA=0x11, OVERRUN=1. ACK -> RX_VALID=0, OVERRUN=0. ACK coincident with the 0x33 completion -> RX_DATA=0x33, RX_VALID=1, OVERRUN=0.
- Mid-frame abort: RST pulsed low, or RX_EN=0, at data bit 4 -> BUSY=0, no RX_VALID. The next frame 0x7E decodes correctly.

Source files
------------

// File: rtl/uart_rx_os32.sv
// rtl/uart_rx_os32.sv - x32-oversampled UART receiver with majority vote and single-entry holding register
module uart_rx_os32 #(
    parameter int DATA_BITS = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 TICK_X32,
    input  logic                 RXD,
    input  logic                 RX_EN,
    input  logic                 PARITY_EN,
    input  logic                 PARITY_ODD,
    input  logic                 RX_ACK,
    output logic [DATA_BITS-1:0] RX_DATA,
    output logic                 RX_VALID,
    output logic                 FRAME_ERR,
    output logic                 PARITY_ERR,
    output logic                 OVERRUN,
    output logic                 BUSY
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

    state_t                 state, state_nxt;
    logic                   sync1, rxs, rxs_d;
    logic [1:0]             vote_hist;
    logic                   vote, fall;
    logic [4:0]             cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_en_l, par_odd_l, perr;
    logic                   mid_tick, end_tick;
    logic                   start_frame, go_data, shift_bit, par_sample, complete, load;

    // The two older register entries plus this tick's sample form the 3-way vote.
    assign vote     = (vote_hist[1] & vote_hist[0]) | (vote_hist[1] & rxs) | (vote_hist[0] & rxs);
    assign fall     = rxs_d & ~rxs;
    assign mid_tick = TICK_X32 && (cnt == 5'd15);
    assign end_tick = TICK_X32 && (cnt == 5'd31);
    assign load     = complete && (!RX_VALID || RX_ACK);
    assign BUSY     = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        go_data     = 1'b0;
        shift_bit   = 1'b0;
        par_sample  = 1'b0;
        complete    = 1'b0;
        if (!RX_EN) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (fall) begin
                    state_nxt   = START;
                    start_frame = 1'b1;
                end
                START: if (mid_tick) begin
                    if (vote) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        go_data   = 1'b1;
                    end
                end
                DATA: if (end_tick) begin
                    shift_bit = 1'b1;
                    if (bit_idx == LAST_IDX)
                        state_nxt = par_en_l ? PARITY : STOP;
                end
                PARITY: if (end_tick) begin
                    par_sample = 1'b1;
                    state_nxt  = STOP;
                end
                STOP: if (end_tick) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            sync1     <= 1'b1;
            rxs       <= 1'b1;
            rxs_d     <= 1'b1;
            vote_hist <= 2'b11;
            cnt       <= 5'd0;
            bit_idx   <= 3'd0;
            shreg     <= '0;
            par_en_l  <= 1'b0;
            par_odd_l <= 1'b0;
            perr      <= 1'b0;
        end else begin
            state <= state_nxt;
            sync1 <= RXD;
            rxs   <= sync1;
            rxs_d <= rxs;
            if (TICK_X32)
                vote_hist <= {vote_hist[0], rxs};
            if (start_frame || go_data)
                cnt <= 5'd0;
            else if (TICK_X32)
                cnt <= cnt + 5'd1;
            if (go_data)
                bit_idx <= 3'd0;
            else if (shift_bit)
                bit_idx <= bit_idx + 3'd1;
            if (shift_bit)
                shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (start_frame) begin
                par_en_l  <= PARITY_EN;
                par_odd_l <= PARITY_ODD;
                perr      <= 1'b0;
            end else if (par_sample) begin
                perr <= (vote != (^shreg ^ par_odd_l));
            end
        end
    end

    // Holding register: a completion either loads or, when still full and unacked, drops.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RX_DATA    <= '0;
            RX_VALID   <= 1'b0;
            FRAME_ERR  <= 1'b0;
            PARITY_ERR <= 1'b0;
            OVERRUN    <= 1'b0;
        end else if (load) begin
            RX_DATA    <= shreg;
            FRAME_ERR  <= ~vote;
            PARITY_ERR <= perr;
            RX_VALID   <= 1'b1;
            if (RX_ACK && RX_VALID)
                OVERRUN <= 1'b0;
        end else if (complete) begin
            OVERRUN <= 1'b1;
        end else if (RX_ACK && RX_VALID) begin
            RX_VALID <= 1'b0;
            OVERRUN  <= 1'b0;
        end
    end

endmodule
